// File: rtl/ddr_pkg.sv
// Shared types and default timing for the DDR command scheduler.
// Timing parameters are in CLK cycles and are expected to be at least 2.
package ddr_pkg;

  localparam int ROW_W  = 15;
  localparam int COL_W  = 10;
  localparam int BANK_W = 3;
  localparam int WAIT_W = 16;

  localparam int DEF_T_REFI  = 64;
  localparam int DEF_T_RFC   = 10;
  localparam int DEF_T_RCD   = 3;
  localparam int DEF_T_RW    = 4;
  localparam int DEF_T_RP    = 3;
  localparam int DEF_REF_MAX = 8;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_REF_ISSUE,
    ST_REF_WAIT,
    ST_ACT_ISSUE,
    ST_ACT_WAIT,
    ST_RW_ISSUE,
    ST_RW_WAIT,
    ST_PRE_ISSUE,
    ST_PRE_WAIT
  } state_t;

  typedef enum logic {
    DIR_WR = 1'b0,
    DIR_RD = 1'b1
  } dir_t;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [BANK_W-1:0] bank;
    dir_t              dir;
  } access_t;

  // A gap of t cycles after an issue cycle spends t-1 cycles in the wait
  // state; the wait counter runs down to zero, so it is loaded with t-2.
  function automatic logic [WAIT_W-1:0] wait_load(input int t);
    return (t < 2) ? '0 : WAIT_W'(t - 2);
  endfunction

endpackage

// File: rtl/ddr_cmd_scheduler_if.sv
// Requester / command-sequencer bundle for the DDR command scheduler.
interface ddr_cmd_scheduler_if;
  import ddr_pkg::*;

  logic              init_done;

  logic              wr_req;
  logic [ROW_W-1:0]  wr_row;
  logic [COL_W-1:0]  wr_col;
  logic [BANK_W-1:0] wr_bank;
  logic              wr_ack;

  logic              rd_req;
  logic [ROW_W-1:0]  rd_row;
  logic [COL_W-1:0]  rd_col;
  logic [BANK_W-1:0] rd_bank;
  logic              rd_ack;

  logic              REF;
  logic              ACT;
  logic              WRITE;
  logic              READ;
  logic              PRE;
  logic [ROW_W-1:0]  Addr_Row;
  logic [COL_W-1:0]  Addr_Column;
  logic [BANK_W-1:0] BA_out;
  logic              A_10;
  logic              A_12;
  logic              ref_overflow;

  modport master (
    output init_done,
    output wr_req, wr_row, wr_col, wr_bank,
    output rd_req, rd_row, rd_col, rd_bank,
    input  wr_ack, rd_ack,
    input  REF, ACT, WRITE, READ, PRE,
    input  Addr_Row, Addr_Column, BA_out, A_10, A_12,
    input  ref_overflow
  );

  modport slave (
    input  init_done,
    input  wr_req, wr_row, wr_col, wr_bank,
    input  rd_req, rd_row, rd_col, rd_bank,
    output wr_ack, rd_ack,
    output REF, ACT, WRITE, READ, PRE,
    output Addr_Row, Addr_Column, BA_out, A_10, A_12,
    output ref_overflow
  );

endinterface

// File: rtl/ddr_ref_timer.sv
// Free-running refresh interval counter and saturating pending-refresh count.
// wrap is a same-cycle lookahead so the scheduler can issue REF on the wrap edge.
module ddr_ref_timer import ddr_pkg::*; #(
  parameter int T_REFI  = DEF_T_REFI,
  parameter int REF_MAX = DEF_REF_MAX,
  localparam int PEND_W = $clog2(REF_MAX + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              ref_issue,
  output logic              wrap,
  output logic [PEND_W-1:0] ref_pend,
  output logic              ref_overflow
);

  localparam int CNT_W = (T_REFI > 1) ? $clog2(T_REFI) : 1;

  logic [CNT_W-1:0]  cnt;
  logic [PEND_W-1:0] pend_next;

  assign wrap = enable && (cnt == CNT_W'(T_REFI - 1));

  always_comb begin
    // NOTE: default assignment first, so every path drives pend_next and no latch is inferred.
    pend_next = ref_pend;
    if (wrap && !ref_issue) begin
      if (ref_pend != PEND_W'(REF_MAX)) pend_next = ref_pend + 1'b1;
    end else if (ref_issue && !wrap && ref_pend != '0) begin
      pend_next = ref_pend - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state, so every register sees pre-edge values.
    if (reset) begin
      cnt          <= '0;
      ref_pend     <= '0;
      ref_overflow <= 1'b0;
    end else begin
      if (enable) cnt <= wrap ? '0 : cnt + 1'b1;
      ref_pend <= pend_next;
      if (pend_next == PEND_W'(REF_MAX)) ref_overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// Closed-page DDR command scheduler: refresh first, then alternating write/read
// grants, each running ACT -> WRITE/READ -> PRE with registered command pulses.
module ddr_cmd_scheduler import ddr_pkg::*; #(
  parameter int T_REFI  = DEF_T_REFI,
  parameter int T_RFC   = DEF_T_RFC,
  parameter int T_RCD   = DEF_T_RCD,
  parameter int T_RW    = DEF_T_RW,
  parameter int T_RP    = DEF_T_RP,
  parameter int REF_MAX = DEF_REF_MAX
) (
  input logic                CLK,
  input logic                RESET,
  ddr_cmd_scheduler_if.slave bus
);

  localparam int PEND_W = $clog2(REF_MAX + 1);

  state_t            state;
  access_t           acc;
  access_t           grant;
  logic              grant_valid;
  logic              toggle_rd;
  logic [WAIT_W-1:0] wait_cnt;

  logic              wrap;
  logic [PEND_W-1:0] ref_pend;
  logic              ref_overflow;
  logic              ref_due;

  logic              cmd_ref, cmd_act, cmd_wr, cmd_rd, cmd_pre;
  logic              wr_ack_q, rd_ack_q;
  logic [ROW_W-1:0]  addr_row;
  logic [COL_W-1:0]  addr_col;
  logic [BANK_W-1:0] ba;
  logic              a10, a12;

  ddr_ref_timer #(
    .T_REFI  (T_REFI),
    .REF_MAX (REF_MAX)
  ) u_ref_timer (
    .clk          (CLK),
    .reset        (RESET),
    .enable       (state != ST_INIT),
    .ref_issue    (state == ST_REF_ISSUE),
    .wrap         (wrap),
    .ref_pend     (ref_pend),
    .ref_overflow (ref_overflow)
  );

  // A wrap this cycle counts as pending so REF lands exactly on the interval.
  assign ref_due     = (ref_pend != '0) || wrap;
  assign grant_valid = bus.wr_req || bus.rd_req;

  always_comb begin
    grant = '{row: bus.wr_row, col: bus.wr_col, bank: bus.wr_bank, dir: DIR_WR};
    if (bus.rd_req && (!bus.wr_req || toggle_rd))
      grant = '{row: bus.rd_row, col: bus.rd_col, bank: bus.rd_bank, dir: DIR_RD};
  end

  // NOTE: the latched access is datapath only; it is written at grant before any state reads it, so it has no reset.
  always_ff @(posedge CLK) begin
    if (state == ST_IDLE && !ref_due && grant_valid) acc <= grant;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_INIT;
      toggle_rd <= 1'b0;
      wait_cnt  <= '0;
      cmd_ref   <= 1'b0;
      cmd_act   <= 1'b0;
      cmd_wr    <= 1'b0;
      cmd_rd    <= 1'b0;
      cmd_pre   <= 1'b0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      addr_row  <= '0;
      addr_col  <= '0;
      ba        <= '0;
      a10       <= 1'b0;
      a12       <= 1'b0;
    end else begin
      cmd_ref  <= 1'b0;
      cmd_act  <= 1'b0;
      cmd_wr   <= 1'b0;
      cmd_rd   <= 1'b0;
      cmd_pre  <= 1'b0;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;

      unique case (state)
        ST_INIT: begin
          if (bus.init_done) state <= ST_IDLE;
        end

        ST_IDLE: begin
          if (ref_due) begin
            state   <= ST_REF_ISSUE;
            cmd_ref <= 1'b1;
          end else if (grant_valid) begin
            state     <= ST_ACT_ISSUE;
            toggle_rd <= (grant.dir == DIR_WR);
            cmd_act   <= 1'b1;
            addr_row  <= grant.row;
            ba        <= grant.bank;
          end
        end

        ST_REF_ISSUE: begin
          state    <= ST_REF_WAIT;
          wait_cnt <= wait_load(T_RFC);
        end

        ST_REF_WAIT: begin
          if (wait_cnt == '0) state <= ST_IDLE;
          else                wait_cnt <= wait_cnt - 1'b1;
        end

        ST_ACT_ISSUE: begin
          state    <= ST_ACT_WAIT;
          wait_cnt <= wait_load(T_RCD);
        end

        ST_ACT_WAIT: begin
          if (wait_cnt == '0) begin
            state    <= ST_RW_ISSUE;
            cmd_wr   <= (acc.dir == DIR_WR);
            cmd_rd   <= (acc.dir == DIR_RD);
            wr_ack_q <= (acc.dir == DIR_WR);
            rd_ack_q <= (acc.dir == DIR_RD);
            addr_col <= acc.col;
            ba       <= acc.bank;
            a10      <= 1'b0;
            a12      <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        ST_RW_ISSUE: begin
          state    <= ST_RW_WAIT;
          wait_cnt <= wait_load(T_RW);
        end

        ST_RW_WAIT: begin
          if (wait_cnt == '0) begin
            state   <= ST_PRE_ISSUE;
            cmd_pre <= 1'b1;
            a10     <= 1'b0;
            ba      <= acc.bank;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        ST_PRE_ISSUE: begin
          state    <= ST_PRE_WAIT;
          wait_cnt <= wait_load(T_RP);
        end

        ST_PRE_WAIT: begin
          if (wait_cnt == '0) state <= ST_IDLE;
          else                wait_cnt <= wait_cnt - 1'b1;
        end

        default: state <= ST_INIT;
      endcase
    end
  end

  assign bus.REF          = cmd_ref;
  assign bus.ACT          = cmd_act;
  assign bus.WRITE        = cmd_wr;
  assign bus.READ         = cmd_rd;
  assign bus.PRE          = cmd_pre;
  assign bus.wr_ack       = wr_ack_q;
  assign bus.rd_ack       = rd_ack_q;
  assign bus.Addr_Row     = addr_row;
  assign bus.Addr_Column  = addr_col;
  assign bus.BA_out       = ba;
  assign bus.A_10         = a10;
  assign bus.A_12         = a12;
  assign bus.ref_overflow = ref_overflow;

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Directed bench for ddr_cmd_scheduler: refresh cadence, access timing,
// arbitration, refresh deferral, reset abort and pending-refresh saturation.
module tb_ddr_cmd_scheduler;
  import ddr_pkg::*;

  localparam logic [4:0] P_REF = 5'b10000;
  localparam logic [4:0] P_ACT = 5'b01000;
  localparam logic [4:0] P_WR  = 5'b00100;
  localparam logic [4:0] P_RD  = 5'b00010;
  localparam logic [4:0] P_PRE = 5'b00001;

  logic CLK = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  ddr_cmd_scheduler_if if_a();
  ddr_cmd_scheduler_if if_b();

  ddr_cmd_scheduler dut_a (.CLK(CLK), .RESET(rst_a), .bus(if_a));

  ddr_cmd_scheduler #(.T_REFI(4)) dut_b (.CLK(CLK), .RESET(rst_b), .bus(if_b));

  typedef struct {
    logic        wr;
    logic        rd;
    logic [14:0] wr_row;
    logic [9:0]  wr_col;
    logic [2:0]  wr_bank;
    logic [14:0] rd_row;
    logic [9:0]  rd_col;
    logic [2:0]  rd_bank;
    logic        exp_rd;
    logic [14:0] exp_row;
    logic [9:0]  exp_col;
    logic [2:0]  exp_bank;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  function automatic logic [4:0] pulses_a();
    return {if_a.REF, if_a.ACT, if_a.WRITE, if_a.READ, if_a.PRE};
  endfunction

  function automatic logic [4:0] pulses_b();
    return {if_b.REF, if_b.ACT, if_b.WRITE, if_b.READ, if_b.PRE};
  endfunction

  task automatic wait_pulse_a(input int bound, output logic [4:0] seen, output int n);
    seen = '0;
    n = 0;
    while (seen == '0 && n < bound) begin
      tick();
      n++;
      seen = pulses_a();
    end
  endtask

  // Waits for a specific pulse, stepping over any other command pulses.
  task automatic wait_for_a(input logic [4:0] want, input int bound, output logic [4:0] seen);
    int n;
    int guard;
    guard = 0;
    do begin
      wait_pulse_a(bound, seen, n);
      guard++;
    end while ((seen & want) == '0 && seen != '0 && guard < 8);
  endtask

  always @(negedge CLK) begin
    check("onehot_a", 32'($countones(pulses_a()) <= 1), 32'd1);
    check("onehot_b", 32'($countones(pulses_b()) <= 1), 32'd1);
  end

  initial begin
    logic [4:0] seen;
    logic [4:0] quiet;
    logic [4:0] p;
    int n;
    int e0;
    int t_pre;
    logic low_seen;
    int max_pend;

    vecs[0] = '{1'b1, 1'b0, 15'h0001, 10'h010, 3'd2, 15'h0000, 10'h000, 3'd0, 1'b0, 15'h0001, 10'h010, 3'd2};
    vecs[1] = '{1'b0, 1'b1, 15'h0000, 10'h000, 3'd0, 15'h7FFF, 10'h3FF, 3'd7, 1'b1, 15'h7FFF, 10'h3FF, 3'd7};
    vecs[2] = '{1'b1, 1'b1, 15'h1234, 10'h155, 3'd5, 15'h0ABC, 10'h2AA, 3'd3, 1'b0, 15'h1234, 10'h155, 3'd5};
    vecs[3] = '{1'b1, 1'b1, 15'h1234, 10'h155, 3'd5, 15'h0ABC, 10'h2AA, 3'd3, 1'b1, 15'h0ABC, 10'h2AA, 3'd3};
    vecs[4] = '{1'b0, 1'b1, 15'h0000, 10'h000, 3'd0, 15'h0000, 10'h000, 3'd0, 1'b1, 15'h0000, 10'h000, 3'd0};
    vecs[5] = '{1'b1, 1'b1, 15'h5555, 10'h0F0, 3'd1, 15'h2222, 10'h00F, 3'd6, 1'b0, 15'h5555, 10'h0F0, 3'd1};

    if_a.init_done = 0; if_a.wr_req = 0; if_a.rd_req = 0;
    if_a.wr_row = '0; if_a.wr_col = '0; if_a.wr_bank = '0;
    if_a.rd_row = '0; if_a.rd_col = '0; if_a.rd_bank = '0;
    if_b.init_done = 0; if_b.wr_req = 0; if_b.rd_req = 0;
    if_b.wr_row = '0; if_b.wr_col = '0; if_b.wr_bank = '0;
    if_b.rd_row = '0; if_b.rd_col = '0; if_b.rd_bank = '0;

    repeat (3) tick();
    check("rst_pulses", 32'(pulses_a()), 32'd0);
    check("rst_acks", 32'({if_a.wr_ack, if_a.rd_ack}), 32'd0);
    check("rst_addr", 32'({if_a.Addr_Row, if_a.Addr_Column, if_a.BA_out, if_a.A_10, if_a.A_12}), 32'd0);
    check("rst_ovf", 32'(if_a.ref_overflow), 32'd0);
    check("rst_state", 32'(dut_a.state), 32'(ST_INIT));

    // INIT must ignore requests and issue nothing.
    rst_a = 0;
    if_a.wr_req = 1; if_a.wr_row = 15'h0042; if_a.wr_bank = 3'd1;
    quiet = '0;
    repeat (6) begin tick(); quiet |= pulses_a(); end
    check("init_quiet", 32'(quiet), 32'd0);
    check("init_state", 32'(dut_a.state), 32'(ST_INIT));

    // Refresh cadence with no traffic.
    if_a.wr_req = 0;
    if_a.init_done = 1;
    tick();
    e0 = cyc;
    check("idle_after_init", 32'(dut_a.state), 32'(ST_IDLE));
    wait_pulse_a(200, seen, n);
    check("first_ref_kind", 32'(seen), 32'(P_REF));
    check("first_ref_delay", 32'(n), 32'd64);
    wait_pulse_a(200, seen, n);
    check("second_ref_kind", 32'(seen), 32'(P_REF));
    check("second_ref_delay", 32'(n), 32'd64);

    // Table-driven single accesses with exact ACT-relative offsets.
    for (int v = 0; v < 6; v++) begin
      if_a.wr_req = vecs[v].wr; if_a.rd_req = vecs[v].rd;
      if_a.wr_row = vecs[v].wr_row; if_a.wr_col = vecs[v].wr_col; if_a.wr_bank = vecs[v].wr_bank;
      if_a.rd_row = vecs[v].rd_row; if_a.rd_col = vecs[v].rd_col; if_a.rd_bank = vecs[v].rd_bank;
      wait_for_a(P_ACT, 40, seen);
      check($sformatf("v%0d_act", v), 32'(seen), 32'(P_ACT));
      check($sformatf("v%0d_row", v), 32'(if_a.Addr_Row), 32'(vecs[v].exp_row));
      check($sformatf("v%0d_act_ba", v), 32'(if_a.BA_out), 32'(vecs[v].exp_bank));
      quiet = '0;
      for (int k = 1; k <= 10; k++) begin
        tick();
        p = pulses_a();
        if (k == 3) begin
          check($sformatf("v%0d_rw", v), 32'(p), 32'(vecs[v].exp_rd ? P_RD : P_WR));
          check($sformatf("v%0d_acks", v), 32'({if_a.wr_ack, if_a.rd_ack}),
                32'({!vecs[v].exp_rd, vecs[v].exp_rd}));
          check($sformatf("v%0d_col", v), 32'(if_a.Addr_Column), 32'(vecs[v].exp_col));
          check($sformatf("v%0d_rw_ba", v), 32'(if_a.BA_out), 32'(vecs[v].exp_bank));
          check($sformatf("v%0d_a10_a12", v), 32'({if_a.A_10, if_a.A_12}), 32'd1);
          if_a.wr_req = 0; if_a.rd_req = 0;
        end else if (k == 7) begin
          check($sformatf("v%0d_pre", v), 32'(p), 32'(P_PRE));
          check($sformatf("v%0d_pre_a10_ba", v), 32'({if_a.A_10, if_a.BA_out}), 32'({1'b0, vecs[v].exp_bank}));
          check($sformatf("v%0d_row_hold", v), 32'(if_a.Addr_Row), 32'(vecs[v].exp_row));
        end else begin
          quiet |= p;
        end
      end
      check($sformatf("v%0d_gaps_quiet", v), 32'(quiet), 32'd0);
    end

    // Interval wraps mid-access: REF must follow PRE_WAIT before the next grant.
    n = 0;
    while (((cyc - e0) % 64) != 56 && n < 200) begin tick(); n++; end
    if_a.wr_req = 1; if_a.wr_row = 15'h0777; if_a.wr_col = 10'h077; if_a.wr_bank = 3'd4;
    wait_pulse_a(5, seen, n);
    check("wrap_act", 32'(seen), 32'(P_ACT));
    check("wrap_act_phase", 32'((cyc - e0) % 64), 32'd57);
    wait_for_a(P_PRE, 20, seen);
    check("wrap_pre", 32'(seen), 32'(P_PRE));
    t_pre = cyc;
    wait_pulse_a(30, seen, n);
    check("wrap_ref_next", 32'(seen), 32'(P_REF));
    check("wrap_ref_gap", 32'(cyc - t_pre), 32'd4);
    wait_pulse_a(30, seen, n);
    check("wrap_act_after_ref", 32'(seen), 32'(P_ACT));
    check("wrap_act_gap", 32'(n), 32'd11);
    wait_for_a(P_WR, 20, seen);
    if_a.wr_req = 0;
    repeat (12) tick();

    // Reset during ACT_WAIT aborts the access.
    if_a.wr_req = 1; if_a.wr_row = 15'h0101; if_a.wr_col = 10'h101; if_a.wr_bank = 3'd6;
    wait_for_a(P_ACT, 40, seen);
    check("abort_act", 32'(seen), 32'(P_ACT));
    tick();
    check("abort_in_act_wait", 32'(dut_a.state), 32'(ST_ACT_WAIT));
    rst_a = 1;
    tick();
    check("abort_pulses", 32'(pulses_a()), 32'd0);
    check("abort_addr", 32'({if_a.Addr_Row, if_a.Addr_Column, if_a.BA_out, if_a.A_10, if_a.A_12}), 32'd0);
    check("abort_acks", 32'({if_a.wr_ack, if_a.rd_ack}), 32'd0);
    check("abort_state", 32'(dut_a.state), 32'(ST_INIT));
    if_a.init_done = 0;
    rst_a = 0;
    quiet = '0;
    repeat (8) begin tick(); quiet |= pulses_a(); end
    check("abort_no_more_pulses", 32'(quiet), 32'd0);

    // Both requesters held: W,R,W,R starting with write after reset.
    if_a.wr_req = 1; if_a.wr_row = 15'h0011; if_a.wr_col = 10'h111; if_a.wr_bank = 3'd1;
    if_a.rd_req = 1; if_a.rd_row = 15'h0022; if_a.rd_col = 10'h222; if_a.rd_bank = 3'd2;
    if_a.init_done = 1;
    for (int i = 0; i < 4; i++) begin
      wait_for_a(P_WR | P_RD, 40, seen);
      check($sformatf("alt%0d_cmd", i), 32'(seen), 32'((i % 2) ? P_RD : P_WR));
      check($sformatf("alt%0d_acks", i), 32'({if_a.wr_ack, if_a.rd_ack}), 32'((i % 2) ? 2'b01 : 2'b10));
      check($sformatf("alt%0d_col", i), 32'(if_a.Addr_Column), 32'((i % 2) ? 10'h222 : 10'h111));
    end
    if_a.wr_req = 0; if_a.rd_req = 0;
    repeat (10) tick();

    // Pending-refresh saturation on the short-interval instance.
    rst_b = 0;
    if_b.init_done = 1;
    if_b.wr_req = 1; if_b.wr_row = 15'h0003; if_b.wr_col = 10'h003; if_b.wr_bank = 3'd3;
    tick();
    check("sat_ovf_clear", 32'(if_b.ref_overflow), 32'd0);
    n = 0;
    max_pend = 0;
    while (!if_b.ref_overflow && n < 300) begin
      tick();
      n++;
      if (int'(dut_b.u_ref_timer.ref_pend) > max_pend) max_pend = int'(dut_b.u_ref_timer.ref_pend);
    end
    check("sat_ovf_set", 32'(if_b.ref_overflow), 32'd1);
    check("sat_pend_at_ovf", 32'(dut_b.u_ref_timer.ref_pend), 32'd8);
    low_seen = 0;
    repeat (60) begin
      tick();
      low_seen |= !if_b.ref_overflow;
      if (int'(dut_b.u_ref_timer.ref_pend) > max_pend) max_pend = int'(dut_b.u_ref_timer.ref_pend);
    end
    check("sat_ovf_sticky", 32'(low_seen), 32'd0);
    check("sat_pend_max", 32'(max_pend), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
